// File: rtl/rgb_to_gray.sv
// rgb_to_gray: front end of the Sobel edge detector.
// Converts {R,G,B} pixels to IMAGE_DW-bit luminance through a 3-stage
// pipeline: Y = (77*R + 150*G + 29*B [+128]) >> 8. Vs/Hs/De are delayed to
// match the data path. A side checker measures De run lengths and lines per
// frame against IMAGE_W x IMAGE_H and flags malformed lines and frames.
// Optional feature: define RGB2GRAY_ROUND_EN to add the 128 rounding constant
// in stage 2 (round-to-nearest). Without it the result is truncated.
module rgb_to_gray #(
    parameter int IMAGE_W  = 640,
    parameter int IMAGE_H  = 480,
    parameter int IMAGE_DW = 8
) (
    input  logic                    InVideoClk,
    input  logic                    InRstN,
    input  logic                    InVideoVs,
    input  logic                    InVideoHs,
    input  logic                    InVideoDe,
    input  logic [3*IMAGE_DW-1:0]   InVideoData,
    output logic                    OutVideoVs,
    output logic                    OutVideoHs,
    output logic                    OutVideoDe,
    output logic [IMAGE_DW-1:0]     OutVideoData,
    output logic                    OutLineErr,
    output logic                    OutFrameErr
);

    localparam int PW  = IMAGE_DW + 8;
    localparam int SW  = IMAGE_DW + 10;
    localparam int PCW = $clog2(IMAGE_W + 1);
    localparam int LCW = $clog2(IMAGE_H + 1);

    localparam logic [PCW-1:0] PIX_MAX   = '1;
    localparam logic [LCW-1:0] LINE_MAX  = '1;
    localparam logic [PCW-1:0] LINE_LEN  = PCW'(IMAGE_W);
    localparam logic [LCW-1:0] FRAME_LEN = LCW'(IMAGE_H);

`ifdef RGB2GRAY_ROUND_EN
    localparam logic [SW-1:0] ROUND_K = SW'(10'd128);
`else
    localparam logic [SW-1:0] ROUND_K = '0;
`endif

    // Channel split: R occupies the most significant byte lane.
    logic [IMAGE_DW-1:0] chanRS;
    logic [IMAGE_DW-1:0] chanGS;
    logic [IMAGE_DW-1:0] chanBS;

    // Stage registers
    logic [PW-1:0] prodRR;
    logic [PW-1:0] prodGR;
    logic [PW-1:0] prodBR;
    logic [SW-1:0] sumR;
    logic          vsD1R, hsD1R, deD1R;
    logic          vsD2R, hsD2R, deD2R;

    // Checker state
    logic           deInR;
    logic           vsInR;
    logic [PCW-1:0] pixCntR;
    logic [LCW-1:0] lineCntR;
    logic           frameBadR;
    logic           armedR;

    // Checker combinational terms
    logic           deFallS;
    logic           vsRiseS;
    logic           lineBadS;
    logic           frameBadNextS;
    logic [LCW-1:0] lineCntNextS;

    // Split the packed pixel into its three colour channels.
    always_comb begin
        chanRS = InVideoData[3*IMAGE_DW-1:2*IMAGE_DW];
        chanGS = InVideoData[2*IMAGE_DW-1:IMAGE_DW];
        chanBS = InVideoData[IMAGE_DW-1:0];
    end

    // Three-stage luminance pipeline with matched sync delays.
    always_ff @(posedge InVideoClk or negedge InRstN) begin
        if (!InRstN) begin
            prodRR       <= '0;
            prodGR       <= '0;
            prodBR       <= '0;
            sumR         <= '0;
            vsD1R        <= 1'b0;
            hsD1R        <= 1'b0;
            deD1R        <= 1'b0;
            vsD2R        <= 1'b0;
            hsD2R        <= 1'b0;
            deD2R        <= 1'b0;
            OutVideoVs   <= 1'b0;
            OutVideoHs   <= 1'b0;
            OutVideoDe   <= 1'b0;
            OutVideoData <= '0;
        end else begin
            // S1: weighted channels; 77+150+29 = 256 so the sum fits in IMAGE_DW+8 bits
            prodRR <= PW'(chanRS) * PW'(8'd77);
            prodGR <= PW'(chanGS) * PW'(8'd150);
            prodBR <= PW'(chanBS) * PW'(8'd29);
            vsD1R  <= InVideoVs;
            hsD1R  <= InVideoHs;
            deD1R  <= InVideoDe;
            // S2: accumulate plus optional rounding constant
            sumR   <= SW'(prodRR) + SW'(prodGR) + SW'(prodBR) + ROUND_K;
            vsD2R  <= vsD1R;
            hsD2R  <= hsD1R;
            deD2R  <= deD1R;
            // S3: divide by 256; blank data outside the active region
            if (deD2R) begin
                OutVideoData <= IMAGE_DW'(sumR >> 8);
            end else begin
                OutVideoData <= '0;
            end
            OutVideoVs <= vsD2R;
            OutVideoHs <= hsD2R;
            OutVideoDe <= deD2R;
        end
    end

    // Edge detection and next-state terms; a De fall coinciding with a Vs
    // rise is folded into the closing frame before it is judged.
    always_comb begin
        deFallS       = deInR & ~InVideoDe;
        vsRiseS       = InVideoVs & ~vsInR;
        lineBadS      = deFallS & (pixCntR != LINE_LEN);
        frameBadNextS = frameBadR | lineBadS;
        if (deFallS && (lineCntR != LINE_MAX)) begin
            lineCntNextS = lineCntR + LCW'(1);
        end else begin
            lineCntNextS = lineCntR;
        end
    end

    // Geometry checker: per-line length and per-frame line count.
    always_ff @(posedge InVideoClk or negedge InRstN) begin
        if (!InRstN) begin
            deInR       <= 1'b0;
            vsInR       <= 1'b0;
            pixCntR     <= '0;
            lineCntR    <= '0;
            frameBadR   <= 1'b0;
            armedR      <= 1'b0;
            OutLineErr  <= 1'b0;
            OutFrameErr <= 1'b0;
        end else begin
            deInR <= InVideoDe;
            vsInR <= InVideoVs;
            // Saturating run-length counter; zero whenever De is low
            if (InVideoDe) begin
                if (pixCntR != PIX_MAX) begin
                    pixCntR <= pixCntR + PCW'(1);
                end else begin
                    pixCntR <= pixCntR;
                end
            end else begin
                pixCntR <= '0;
            end
            OutLineErr <= lineBadS;
            if (vsRiseS) begin
                // The first Vs after reset closes a partial frame: arm only
                if (armedR) begin
                    OutFrameErr <= frameBadNextS | (lineCntNextS != FRAME_LEN);
                end else begin
                    OutFrameErr <= OutFrameErr;
                end
                armedR    <= 1'b1;
                lineCntR  <= '0;
                frameBadR <= 1'b0;
            end else begin
                lineCntR  <= lineCntNextS;
                frameBadR <= frameBadNextS;
            end
        end
    end

endmodule

// File: tb/tb_rgb_to_gray.sv
// Directed bench for rgb_to_gray using a reduced 16x6 geometry inside a
// 24x10 total timing so whole frames stay short.
module tb_rgb_to_gray;

    localparam int W  = 16;
    localparam int H  = 6;
    localparam int HT = 24;
    localparam int VT = 10;
    localparam int VS_LINE = 8;

`ifdef RGB2GRAY_ROUND_EN
    localparam logic [7:0] G_RED  = 8'd77;
    localparam logic [7:0] G_BLUE = 8'd29;
`else
    localparam logic [7:0] G_RED  = 8'd76;
    localparam logic [7:0] G_BLUE = 8'd28;
`endif

    typedef struct {
        logic [23:0] rgb;
        logic [7:0]  gray;
    } vec_t;

    localparam int NV = 7;
    vec_t vecs [NV];

    logic        clk = 1'b0;
    logic        rstN = 1'b0;
    logic        vs = 1'b0;
    logic        hs = 1'b0;
    logic        de = 1'b0;
    logic [23:0] data = 24'd0;
    logic        outVs, outHs, outDe, outLineErr, outFrameErr;
    logic [7:0]  outData;

    int errors = 0;
    int checks = 0;
    int lePulses = 0;
    int rstHold = 0;

    // Reference model state
    logic [10:0] hist [3];
    logic        mPrevDe, mPrevVs, mBad, mArmed, mLE, mFE;
    int          mRun, mLines;

    rgb_to_gray #(.IMAGE_W(W), .IMAGE_H(H), .IMAGE_DW(8)) dut (
        .InVideoClk   (clk),
        .InRstN       (rstN),
        .InVideoVs    (vs),
        .InVideoHs    (hs),
        .InVideoDe    (de),
        .InVideoData  (data),
        .OutVideoVs   (outVs),
        .OutVideoHs   (outHs),
        .OutVideoDe   (outDe),
        .OutVideoData (outData),
        .OutLineErr   (outLineErr),
        .OutFrameErr  (outFrameErr)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic modelReset();
        for (int i = 0; i < 3; i++) hist[i] = 11'd0;
        mPrevDe = 1'b0; mPrevVs = 1'b0; mBad = 1'b0; mArmed = 1'b0;
        mLE = 1'b0; mFE = 1'b0; mRun = 0; mLines = 0;
    endtask

    // Apply one cycle of inputs, advance past the edge, update model, compare.
    task automatic cyc(input logic v, input logic h, input logic d,
                       input logic [23:0] px, input logic [7:0] g);
        logic fall, rise, badN;
        int   linesN;
        vs = v; hs = h; de = d; data = px;
        @(posedge clk);
        #1;
        if (!rstN) begin
            modelReset();
        end else begin
            fall   = mPrevDe && !d;
            rise   = v && !mPrevVs;
            mLE    = fall && (mRun != W);
            linesN = mLines + (fall ? 1 : 0);
            badN   = mBad | mLE;
            if (rise) begin
                if (mArmed) mFE = badN || (linesN != H);
                mArmed = 1'b1;
                mLines = 0;
                mBad   = 1'b0;
            end else begin
                mLines = linesN;
                mBad   = badN;
            end
            mRun    = d ? mRun + 1 : 0;
            mPrevDe = d;
            mPrevVs = v;
            hist[2] = hist[1];
            hist[1] = hist[0];
            hist[0] = {v, h, d, (d ? g : 8'd0)};
        end
        check("video", {21'd0, outVs, outHs, outDe, outData}, {21'd0, hist[2]});
        check("lineErr", {31'd0, outLineErr}, {31'd0, mLE});
        check("frameErr", {31'd0, outFrameErr}, {31'd0, mFE});
        if (outLineErr) lePulses++;
    endtask

    // One full frame of white pixels; Vs rises at line VS_LINE.
    task automatic frame(input string name, input int nLines, input int shortLine,
                         input int rstLine, input logic expFE, input int expPulses);
        lePulses = 0;
        for (int ln = 0; ln < VT; ln++) begin
            for (int px = 0; px < HT; px++) begin
                logic d, h, v;
                d = (ln < nLines) && (px < ((ln == shortLine) ? W - 1 : W));
                h = (px >= 18) && (px < 20);
                v = (ln == VS_LINE);
                cyc(v, h, d, 24'hFFFFFF, 8'd255);
                if (rstHold > 0) begin
                    rstHold--;
                    if (rstHold == 0) rstN = 1'b1;
                end
                if (ln == rstLine && px == 5) begin
                    rstN = 1'b0;
                    #1;
                    check({name, " rstVideo"}, {21'd0, outVs, outHs, outDe, outData}, 32'd0);
                    check({name, " rstErr"}, {30'd0, outLineErr, outFrameErr}, 32'd0);
                    modelReset();
                    rstHold = 2;
                end
            end
        end
        check({name, " frameErr"}, {31'd0, outFrameErr}, {31'd0, expFE});
        check({name, " linePulses"}, lePulses, expPulses);
    endtask

    initial begin
        vecs[0] = '{24'hFFFFFF, 8'd255};
        vecs[1] = '{24'h000000, 8'd0};
        vecs[2] = '{24'hFF0000, G_RED};
        vecs[3] = '{24'h00FF00, 8'd149};
        vecs[4] = '{24'h0000FF, G_BLUE};
        vecs[5] = '{24'h808080, 8'd128};
        vecs[6] = '{24'h6432C8, 8'd82};
        modelReset();

        // Reset held while inputs toggle
        rstN = 1'b0;
        for (int i = 0; i < 6; i++) begin
            cyc((i % 2) == 1, (i % 3) == 0, (i % 2) == 0, 24'hA5A5A5 ^ 24'(i), 8'd0);
        end
        rstN = 1'b1;
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b0, 24'd0, 8'd0);

        // Colour table on consecutive De cycles; output lags by three cycles
        for (int i = 0; i < NV + 2; i++) begin
            if (i < NV) cyc(1'b0, 1'b0, 1'b1, vecs[i].rgb, vecs[i].gray);
            else        cyc(1'b0, 1'b0, 1'b0, 24'd0, 8'd0);
            if (i >= 2) begin
                check("gray vec", {24'd0, outData}, {24'd0, vecs[i-2].gray});
                check("de vec", {31'd0, outDe}, 32'd1);
            end else begin
                check("de latency", {31'd0, outDe}, 32'd0);
            end
        end
        cyc(1'b0, 1'b0, 1'b0, 24'd0, 8'd0);
        check("de after run", {31'd0, outDe}, 32'd0);
        for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, 1'b0, 24'd0, 8'd0);

        // Frame sequence
        frame("arm",      H,     -1, -1, 1'b0, 0);
        frame("clean1",   H,     -1, -1, 1'b0, 0);
        frame("shortLn",  H,      2, -1, 1'b1, 1);
        frame("clean2",   H,     -1, -1, 1'b0, 0);
        frame("fewLines", H - 1, -1, -1, 1'b1, 0);
        frame("reset",    H,     -1,  2, 1'b0, 1);
        frame("clean3",   H,     -1, -1, 1'b0, 0);
        frame("shortLn2", H,      4, -1, 1'b1, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
